mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Merges the processor's two memory clients (instruction fetch, data load/store) onto one
//   shared memory port; sits directly below the core, between its inst_mem/data_mem client
//   ports and a single-ported memory or cache.
// - Round-robin arbitration of requests. An in-order source-ID FIFO routes each response
//   back to the client that issued the request; opaque fields pass through untouched.
// PARAMETERS
// p_opaq_bits        8   width of request/response opaque field (passed through unmodified)
// p_max_outstanding  4   source-ID FIFO depth = max in-flight requests (power of 2, >=2)
// PORTS (REQ = {op[1], opaque[p_opaq_bits], addr[32], len[2], data[32]}; op 0=read 1=write)
// (RESP = {op[1], opaque[p_opaq_bits], len[2], data[32]})
// clk            in   1        clock, all state on rising edge
// rst            in   1        asynchronous reset, active-low
// imem_req_val   in   1        instruction client request valid
// imem_req_rdy   out  1        instruction client request ready
// imem_req_msg   in   REQ      instruction client request
// imem_resp_val  out  1        instruction client response valid
// imem_resp_rdy  in   1        instruction client response ready
// imem_resp_msg  out  RESP     instruction client response
// dmem_req_val/rdy/msg, dmem_resp_val/rdy/msg   as imem_*, for the data client
// mem_req_val    out  1        shared port request valid
// mem_req_rdy    in   1        shared port request ready
// mem_req_msg    out  REQ      shared port request (copy of granted client's msg)
// mem_resp_val   in   1        shared port response valid
// mem_resp_rdy   out  1        shared port response ready
// mem_resp_msg   in   RESP     shared port response
// BEHAVIOUR
// - State: last_grant (1b; 0=imem, 1=dmem); FIFO of 1b source IDs with wr_ptr, rd_ptr and
//   count (0..p_max_outstanding); pointers wrap modulo depth.
// - Reset (rst=0, async): last_grant=1 (imem wins the first tie), pointers/count=0. Outputs
//   during reset: all *_val=0, all *_rdy=0.
// - Grant (comb): only one valid -> that client; both valid -> client != last_grant.
// - Request path is combinational, zero added latency: mem_req_val = granted val & !full;
//   mem_req_msg = granted msg; granted client's req_rdy = mem_req_rdy & !full; the other
//   client's req_rdy = 0.
// - Request fire (mem_req_val & mem_req_rdy): push granted ID, last_grant <= granted ID.
//   No fire -> last_grant holds; a stalled grant is not switched while its val stays high,
//   unless the other client also asserts val (then normal round-robin applies).
// - Response path (comb): head ID selects the target; target resp_val = mem_resp_val &
//   !empty; target resp_msg = mem_resp_msg; mem_resp_rdy = target resp_rdy & !empty;
//   non-target resp_val = 0. Response fire pops the FIFO.
// - Responses are returned by memory in request order; no reordering is performed.
// - Empty: mem_resp_rdy=0, both resp_val=0 (a stray response is held off, never dropped).
// - Full: mem_req_val=0, both req_rdy=0. A pop in the same cycle does not enable a push
//   (no full-bypass); the push proceeds the next cycle.
// - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers
//   advance. A response cannot bypass its own request's push (empty -> no resp accepted).
// - Reset asserted mid-transaction: all in-flight IDs are discarded. Memory is reset with
//   the block and sends no responses for those requests.
// - Assertions (sim): count never exceeds depth; no pop when empty.
// TESTING
// 1 Reset, imem only val, addr 0x200, mem_req_rdy=1 -> mem_req_msg.addr=0x200 same cycle; resp
//   data 0xDEADBEEF -> imem_resp_val=1 with that data, dmem_resp_val=0.
// 2 Both val every cycle, rdy=1 -> grants imem,dmem,imem,dmem; 4 in-order resps route i,d,i,d.
// 3 Issue 4 reqs with no resp -> count=4, 5th: both req_rdy=0, mem_req_val=0; resp+pop same
//   cycle -> push still blocked that cycle, accepted next cycle.
// 4 imem_resp_rdy=0 with imem at FIFO head -> mem_resp_rdy=0, FIFO held; dmem resp not
//   delivered ahead of it.
// 5 mem_resp_val=1 while empty -> mem_resp_rdy=0, no client resp_val.
// 6 rst low with 3 outstanding -> all val/rdy 0 immediately; after release, count=0 and imem
//   wins the first tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-client memory port arbiter: round-robin request grant onto one shared port,
// with an in-order source-ID FIFO that steers each response back to its requester.
module mem_port_arbiter #(
  parameter int p_opaq_bits       = 8,
  parameter int p_max_outstanding = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   imem_req_val,
  output logic                   imem_req_rdy,
  input  logic [p_opaq_bits+66:0] imem_req_msg,
  output logic                   imem_resp_val,
  input  logic                   imem_resp_rdy,
  output logic [p_opaq_bits+34:0] imem_resp_msg,

  input  logic                   dmem_req_val,
  output logic                   dmem_req_rdy,
  input  logic [p_opaq_bits+66:0] dmem_req_msg,
  output logic                   dmem_resp_val,
  input  logic                   dmem_resp_rdy,
  output logic [p_opaq_bits+34:0] dmem_resp_msg,

  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_opaq_bits+66:0] mem_req_msg,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits+34:0] mem_resp_msg
);

  localparam int ptr_bits = $clog2(p_max_outstanding);
  localparam logic [ptr_bits:0] depth = p_max_outstanding[ptr_bits:0];
  localparam logic id_imem = 1'b0;
  localparam logic id_dmem = 1'b1;

  logic                     last_grant;
  logic [p_max_outstanding-1:0] id_fifo;
  logic [ptr_bits-1:0]      wr_ptr;
  logic [ptr_bits-1:0]      rd_ptr;
  logic [ptr_bits:0]        count;

  logic grant_id;
  logic head_id;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full    = (count == depth);
  assign empty   = (count == '0);
  assign head_id = id_fifo[rd_ptr];

  // Contention alternates away from the last winner; a lone requester always wins.
  assign grant_id = (imem_req_val && dmem_req_val) ? ~last_grant : dmem_req_val;

  // Every handshake output is forced low while reset is held, independent of the clock.
  always_comb begin
    mem_req_val  = rst && (imem_req_val || dmem_req_val) && !full;
    mem_req_msg  = (grant_id == id_dmem) ? dmem_req_msg : imem_req_msg;
    imem_req_rdy = rst && (grant_id == id_imem) && mem_req_rdy && !full;
    dmem_req_rdy = rst && (grant_id == id_dmem) && mem_req_rdy && !full;

    imem_resp_val = rst && mem_resp_val && !empty && (head_id == id_imem);
    dmem_resp_val = rst && mem_resp_val && !empty && (head_id == id_dmem);
    imem_resp_msg = mem_resp_msg;
    dmem_resp_msg = mem_resp_msg;
    mem_resp_rdy  = rst && !empty &&
                    ((head_id == id_dmem) ? dmem_resp_rdy : imem_resp_rdy);
  end

  assign push = mem_req_val && mem_req_rdy;
  assign pop  = mem_resp_val && mem_resp_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= id_dmem;
      id_fifo    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant_id;
        wr_ptr          <= wr_ptr + ptr_bits'(1);
        last_grant      <= grant_id;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_bits'(1);
      end
      if (push && !pop) begin
        count <= count + (ptr_bits+1)'(1);
      end else if (pop && !push) begin
        count <= count - (ptr_bits+1)'(1);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (count <= depth);
      assert (!(pop && empty));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and outputs
// are checked 1ns later, so every check sees settled combinational paths.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_val = 1'b0, imem_req_rdy;
  logic [74:0] imem_req_msg = '0;
  logic        imem_resp_val, imem_resp_rdy = 1'b0;
  logic [42:0] imem_resp_msg;
  logic        dmem_req_val = 1'b0, dmem_req_rdy;
  logic [74:0] dmem_req_msg = '0;
  logic        dmem_resp_val, dmem_resp_rdy = 1'b0;
  logic [42:0] dmem_resp_msg;
  logic        mem_req_val, mem_req_rdy = 1'b0;
  logic [74:0] mem_req_msg;
  logic        mem_resp_val = 1'b0, mem_resp_rdy;
  logic [42:0] mem_resp_msg = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.p_opaq_bits(8), .p_max_outstanding(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_val(imem_req_val), .imem_req_rdy(imem_req_rdy), .imem_req_msg(imem_req_msg),
    .imem_resp_val(imem_resp_val), .imem_resp_rdy(imem_resp_rdy), .imem_resp_msg(imem_resp_msg),
    .dmem_req_val(dmem_req_val), .dmem_req_rdy(dmem_req_rdy), .dmem_req_msg(dmem_req_msg),
    .dmem_resp_val(dmem_resp_val), .dmem_resp_rdy(dmem_resp_rdy), .dmem_resp_msg(dmem_resp_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
  );

  function automatic logic [74:0] mk_req(input logic op, input logic [7:0] opq,
                                         input logic [31:0] addr, input logic [1:0] len,
                                         input logic [31:0] data);
    return {op, opq, addr, len, data};
  endfunction

  function automatic logic [42:0] mk_resp(input logic op, input logic [7:0] opq,
                                          input logic [1:0] len, input logic [31:0] data);
    return {op, opq, len, data};
  endfunction

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b0;
    imem_req_val = 1'b0; dmem_req_val = 1'b0; mem_resp_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [74:0] ireq, dreq;
  logic [42:0] rsp;

  initial begin
    // Reset: outputs held low even with every input asserted
    imem_req_val = 1'b1; dmem_req_val = 1'b1; mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    settle();
    chk("rst mem_req_val", 75'(mem_req_val), 75'(0));
    chk("rst imem_req_rdy", 75'(imem_req_rdy), 75'(0));
    chk("rst dmem_req_rdy", 75'(dmem_req_rdy), 75'(0));
    chk("rst mem_resp_rdy", 75'(mem_resp_rdy), 75'(0));
    chk("rst imem_resp_val", 75'(imem_resp_val), 75'(0));
    chk("rst dmem_resp_val", 75'(dmem_resp_val), 75'(0));
    pulse_reset();

    // 1: single imem read at 0x200 then its response
    ireq = mk_req(1'b0, 8'h11, 32'h0000_0200, 2'd0, 32'h0);
    imem_req_msg = ireq; imem_req_val = 1'b1; dmem_req_val = 1'b0;
    settle();
    chk("t1 mem_req_val", 75'(mem_req_val), 75'(1));
    chk("t1 mem_req_msg", mem_req_msg, ireq);
    chk("t1 addr", 75'(mem_req_msg[65:34]), 75'(32'h200));
    chk("t1 imem_req_rdy", 75'(imem_req_rdy), 75'(1));
    chk("t1 dmem_req_rdy", 75'(dmem_req_rdy), 75'(0));
    step();
    imem_req_val = 1'b0;
    rsp = mk_resp(1'b0, 8'h11, 2'd0, 32'hDEAD_BEEF);
    mem_resp_msg = rsp; mem_resp_val = 1'b1;
    settle();
    chk("t1 imem_resp_val", 75'(imem_resp_val), 75'(1));
    chk("t1 imem_resp_msg", 75'(imem_resp_msg), 75'(rsp));
    chk("t1 dmem_resp_val", 75'(dmem_resp_val), 75'(0));
    chk("t1 mem_resp_rdy", 75'(mem_resp_rdy), 75'(1));
    step();
    mem_resp_val = 1'b0;

    // 2: contention from reset alternates imem, dmem, imem, dmem
    pulse_reset();
    ireq = mk_req(1'b0, 8'hA1, 32'h0000_1000, 2'd0, 32'h0);
    dreq = mk_req(1'b1, 8'hB2, 32'h0000_2000, 2'd3, 32'h1234_5678);
    imem_req_msg = ireq; dmem_req_msg = dreq;
    imem_req_val = 1'b1; dmem_req_val = 1'b1; mem_req_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t2 grant%0d msg", k), mem_req_msg, (k % 2 == 0) ? ireq : dreq);
      chk($sformatf("t2 grant%0d irdy", k), 75'(imem_req_rdy), 75'(k % 2 == 0));
      chk($sformatf("t2 grant%0d drdy", k), 75'(dmem_req_rdy), 75'(k % 2 == 1));
      step();
    end
    settle();
    chk("t2 full mem_req_val", 75'(mem_req_val), 75'(0));
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    mem_resp_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_resp_msg = mk_resp(1'b0, 8'(k), 2'd0, 32'hC0DE_0000 + 32'(k));
      settle();
      chk($sformatf("t2 resp%0d ival", k), 75'(imem_resp_val), 75'(k % 2 == 0));
      chk($sformatf("t2 resp%0d dval", k), 75'(dmem_resp_val), 75'(k % 2 == 1));
      chk($sformatf("t2 resp%0d data", k),
          75'((k % 2 == 0) ? imem_resp_msg[31:0] : dmem_resp_msg[31:0]),
          75'(32'hC0DE_0000 + 32'(k)));
      step();
    end
    mem_resp_val = 1'b0;

    // 3: fill with four imem reqs, then a pop does not open a same-cycle push
    imem_req_val = 1'b1;
    for (int k = 0; k < 4; k++) step();
    dmem_req_val = 1'b1;
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_resp(1'b0, 8'h33, 2'd0, 32'h0000_0033);
    settle();
    chk("t3 full irdy", 75'(imem_req_rdy), 75'(0));
    chk("t3 full drdy", 75'(dmem_req_rdy), 75'(0));
    chk("t3 full mem_req_val", 75'(mem_req_val), 75'(0));
    chk("t3 pop ival", 75'(imem_resp_val), 75'(1));
    chk("t3 pop mem_resp_rdy", 75'(mem_resp_rdy), 75'(1));
    step();
    mem_resp_val = 1'b0;
    settle();
    chk("t3 after pop mem_req_val", 75'(mem_req_val), 75'(1));
    chk("t3 after pop grant dmem", mem_req_msg, dreq);
    chk("t3 after pop drdy", 75'(dmem_req_rdy), 75'(1));
    step();
    imem_req_val = 1'b0; dmem_req_val = 1'b0;

    // 4: FIFO holds i,i,i,d; stalled imem head blocks everything behind it
    imem_resp_rdy = 1'b0;
    mem_resp_val = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("t4 stall%0d mem_resp_rdy", k), 75'(mem_resp_rdy), 75'(0));
      chk($sformatf("t4 stall%0d ival", k), 75'(imem_resp_val), 75'(1));
      chk($sformatf("t4 stall%0d dval", k), 75'(dmem_resp_val), 75'(0));
      step();
    end
    imem_resp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t4 drain%0d ival", k), 75'(imem_resp_val), 75'(k < 3));
      chk($sformatf("t4 drain%0d dval", k), 75'(dmem_resp_val), 75'(k == 3));
      step();
    end

    // 5: stray response while empty is held off
    settle();
    chk("t5 mem_resp_rdy", 75'(mem_resp_rdy), 75'(0));
    chk("t5 ival", 75'(imem_resp_val), 75'(0));
    chk("t5 dval", 75'(dmem_resp_val), 75'(0));
    mem_resp_val = 1'b0;

    // 6: reset with three outstanding, then imem wins the first tie from empty
    dmem_req_val = 1'b1;
    for (int k = 0; k < 3; k++) step();
    imem_req_val = 1'b1; mem_resp_val = 1'b1;
    #3;
    rst = 1'b0;
    settle();
    chk("t6 rst mem_req_val", 75'(mem_req_val), 75'(0));
    chk("t6 rst irdy", 75'(imem_req_rdy), 75'(0));
    chk("t6 rst drdy", 75'(dmem_req_rdy), 75'(0));
    chk("t6 rst mem_resp_rdy", 75'(mem_resp_rdy), 75'(0));
    chk("t6 rst dval", 75'(dmem_resp_val), 75'(0));
    step();
    rst = 1'b1;
    settle();
    chk("t6 empty mem_resp_rdy", 75'(mem_resp_rdy), 75'(0));
    chk("t6 tie grant imem", mem_req_msg, ireq);
    chk("t6 tie irdy", 75'(imem_req_rdy), 75'(1));
    mem_resp_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t6 refill%0d mem_req_val", k), 75'(mem_req_val), 75'(1));
      step();
    end
    settle();
    chk("t6 refill full", 75'(mem_req_val), 75'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
